// File: rtl/gol_board_arbiter.sv
// gol_board_arbiter: single-port board RAM arbiter (display first, upd/wr round-robin with starvation override)
module gol_board_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  input  logic              upd_req,
  input  logic [ADDR_W-1:0] upd_addr,
  output logic              upd_gnt,
  output logic              upd_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_gnt,
  output logic              rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic              disp_miss,
  output logic [15:0]       miss_count
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [3:0]  upd_wait_q, upd_wait_d, wr_wait_q, wr_wait_d;
  logic        rr_q, rr_d;
  logic        disp_rvalid_q, disp_rvalid_d, upd_rvalid_q, upd_rvalid_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic        upd_starve, wr_starve, starve, pick_upd;
  // rr_q == 0 prefers upd; starvation only counts while the requester is still asking
  always_comb begin
    upd_starve    = upd_req && upd_wait_q == MW;
    wr_starve     = wr_req && wr_wait_q == MW;
    starve        = upd_starve || wr_starve;
    pick_upd      = upd_req && (!wr_req || !rr_q);
    disp_gnt      = !reset && disp_req && !starve;
    upd_gnt       = !reset && (starve ? upd_starve && (!wr_starve || !rr_q) : !disp_req && pick_upd);
    wr_gnt        = !reset && (starve ? !(upd_starve && (!wr_starve || !rr_q)) : !disp_req && wr_req && !pick_upd);
    rr_d          = upd_gnt ? 1'b1 : wr_gnt ? 1'b0 : rr_q;
    upd_wait_d    = (!upd_req || upd_gnt) ? 4'd0 : upd_wait_q == MW ? MW : upd_wait_q + 4'd1;
    wr_wait_d     = (!wr_req || wr_gnt) ? 4'd0 : wr_wait_q == MW ? MW : wr_wait_q + 4'd1;
    mem_en        = disp_gnt || upd_gnt || wr_gnt;
    mem_we        = wr_gnt;
    mem_addr      = disp_gnt ? disp_addr : upd_gnt ? upd_addr : wr_gnt ? wr_addr : '0;
    mem_wdata     = wr_gnt && wr_data;
    disp_miss     = disp_req && !disp_gnt;
    miss_count_d  = (disp_miss && miss_count_q != 16'hFFFF) ? miss_count_q + 16'd1 : miss_count_q;
    disp_rvalid_d = disp_gnt;
    upd_rvalid_d  = upd_gnt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_wait_q    <= '0;
      wr_wait_q     <= '0;
      rr_q          <= 1'b0;
      disp_rvalid_q <= 1'b0;
      upd_rvalid_q  <= 1'b0;
      miss_count_q  <= '0;
    end else begin
      upd_wait_q    <= upd_wait_d;
      wr_wait_q     <= wr_wait_d;
      rr_q          <= rr_d;
      disp_rvalid_q <= disp_rvalid_d;
      upd_rvalid_q  <= upd_rvalid_d;
      miss_count_q  <= miss_count_d;
    end
  end
  assign disp_rvalid = disp_rvalid_q;
  assign upd_rvalid  = upd_rvalid_q;
  assign miss_count  = miss_count_q;
  assign rdata       = mem_rdata;
endmodule

// File: tb/tb_gol_board_arbiter.sv
// tb_gol_board_arbiter: directed checks of grant order, RAM path, reset and miss saturation
module tb_gol_board_arbiter;
  logic clk = 0, reset = 1;
  logic disp_req = 0, upd_req = 0, wr_req = 0, wr_data = 0;
  logic [7:0] disp_addr = 0, upd_addr = 0, wr_addr = 0;
  logic disp_gnt, disp_rvalid, upd_gnt, upd_rvalid, wr_gnt, rdata;
  logic mem_en, mem_we, mem_wdata, mem_rdata = 0, disp_miss;
  logic [7:0] mem_addr;
  logic [15:0] miss_count;
  logic b_reset = 1, b_req = 0, b_rdata_in = 0;
  logic b_dg, b_dv, b_ug, b_uv, b_wg, b_rd, b_en, b_we, b_wd, b_miss;
  logic [7:0] b_addr;
  logic [15:0] b_cnt;
  logic ram [256];
  int n = 0, errs = 0;
  always #5 clk = ~clk;
  gol_board_arbiter #(.ADDR_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .upd_req(upd_req), .upd_addr(upd_addr), .upd_gnt(upd_gnt),
    .upd_rvalid(upd_rvalid), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .disp_miss(disp_miss), .miss_count(miss_count));
  gol_board_arbiter #(.ADDR_W(8), .MAX_WAIT(1)) dut_b (
    .clk(clk), .reset(b_reset), .disp_req(b_req), .disp_addr(8'h01), .disp_gnt(b_dg),
    .disp_rvalid(b_dv), .upd_req(b_req), .upd_addr(8'h02), .upd_gnt(b_ug),
    .upd_rvalid(b_uv), .wr_req(b_req), .wr_addr(8'h03), .wr_data(1'b1), .wr_gnt(b_wg),
    .rdata(b_rd), .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
    .mem_rdata(b_rdata_in), .disp_miss(b_miss), .miss_count(b_cnt));
  // write-first single-port RAM model
  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 0;
    // reset holds grants low even with requests present
    @(negedge clk); disp_req = 1; upd_req = 1; disp_addr = 8'h11; upd_addr = 8'h22; #1;
    chk("rst_gnts", {disp_gnt, upd_gnt, wr_gnt}, 0);
    chk("rst_rvalid", {disp_rvalid, upd_rvalid}, 0);
    chk("rst_mem", {mem_en, mem_we}, 0);
    chk("rst_miss", miss_count, 0);
    // display vs update starvation
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); if (c == 0) reset = 0; #1;
      chk($sformatf("st_disp%0d", c), disp_gnt, c != 4);
      chk($sformatf("st_upd%0d", c), upd_gnt, c == 4);
      chk($sformatf("st_miss%0d", c), disp_miss, c == 4);
      chk($sformatf("st_cnt%0d", c), miss_count, c > 4);
      chk($sformatf("st_dv%0d", c), disp_rvalid, c > 0 && c != 5);
      chk($sformatf("st_uv%0d", c), upd_rvalid, c == 5);
      chk($sformatf("st_addr%0d", c), mem_addr, c == 4 ? 8'h22 : 8'h11);
    end
    // round robin upd/wr
    @(negedge clk); reset = 1; disp_req = 0; upd_req = 0;
    @(negedge clk); reset = 0; upd_req = 1; wr_req = 1; upd_addr = 8'h03; wr_addr = 8'h07; wr_data = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("rr_upd%0d", c), upd_gnt, c % 2 == 0);
      chk($sformatf("rr_wr%0d", c), wr_gnt, c % 2 == 1);
      chk($sformatf("rr_we%0d", c), mem_we, c % 2 == 1);
      chk($sformatf("rr_uv%0d", c), upd_rvalid, c % 2 == 1);
    end
    // write then read back the same cell
    @(negedge clk); upd_req = 0; wr_req = 1; wr_addr = 8'h25; wr_data = 1; #1;
    chk("wr_gnt", wr_gnt, 1);
    chk("wr_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h25, 1'b1});
    @(negedge clk); wr_req = 0; upd_req = 1; upd_addr = 8'h25; #1;
    chk("rd_gnt", upd_gnt, 1);
    chk("rd_mem", {mem_en, mem_we, mem_addr}, {2'b10, 8'h25});
    chk("rd_uv_pre", upd_rvalid, 0);
    @(negedge clk); upd_req = 0; wr_req = 1; wr_data = 0; #1;
    chk("rd_uv", upd_rvalid, 1);
    chk("rd_data1", rdata, 1);
    chk("rd_dv", disp_rvalid, 0);
    chk("wr0_gnt", wr_gnt, 1);
    @(negedge clk); wr_req = 0; upd_req = 1; #1;
    chk("rd2_uv_pre", upd_rvalid, 0);
    @(negedge clk); upd_req = 0; #1;
    chk("rd2_uv", upd_rvalid, 1);
    chk("rd_data0", rdata, 0);
    chk("idle_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    // three-way contention
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; disp_req = 1; upd_req = 1; wr_req = 1; disp_addr = 8'h10;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("all_g%0d", c), {disp_gnt, upd_gnt, wr_gnt},
          c < 4 ? 3'b100 : (c - 4) % 5 == 0 ? 3'b010 : (c - 4) % 5 == 1 ? 3'b001 : 3'b100);
    end
    // reset while a display read is in flight
    @(negedge clk); upd_req = 0; wr_req = 0; #1;
    chk("pre_cnt", miss_count, 7);
    chk("pre_dg", disp_gnt, 1);
    @(negedge clk); #1;
    chk("pre_dv", disp_rvalid, 1);
    reset = 1; #1;
    chk("async_dv", disp_rvalid, 0);
    chk("async_cnt", miss_count, 0);
    chk("async_dg", disp_gnt, 0);
    @(negedge clk); #1;
    chk("rst_dv2", disp_rvalid, 0);
    @(negedge clk); reset = 0; upd_req = 1; #1;
    chk("post_rst_g", {disp_gnt, upd_gnt, wr_gnt}, 3'b100);
    @(negedge clk); disp_req = 0; upd_req = 0;
    // miss counter saturation (MAX_WAIT=1 denies display every cycle after the first)
    @(negedge clk); b_reset = 0; b_req = 1;
    repeat (65535) @(negedge clk);
    #1; chk("sat_fffe", b_cnt, 16'hFFFE);
    @(negedge clk); #1; chk("sat_ffff", b_cnt, 16'hFFFF);
    repeat (4500) @(negedge clk);
    #1; chk("sat_hold", b_cnt, 16'hFFFF);
    chk("sat_miss", b_miss, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule
